// File: rtl/bus_line_responder_pkg.sv
// Shared bus/memory message codes and the log2 helper used by the line responder.
// Codes are plain ints so each user can size them to its own message width.
package bus_line_responder_pkg;

  localparam int NO_REQ     = 0;
  localparam int R_REQ      = 1;
  localparam int WB_REQ     = 2;
  localparam int MEM_RESP   = 3;
  localparam int MEM_RESP_S = 4;

  // Ceiling log2; exact for the power-of-two sizes used here, log2(1) = 0.
  function automatic int log2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/bus_line_responder.sv
// Bus-side responder for one L1 line: collects write-back beats into a line for
// memory, or fetches a line from memory and returns it to the requester beat by beat.
module bus_line_responder
  import bus_line_responder_pkg::*;
#(
  parameter int DATA_WIDTH       = 32,
  parameter int ADDRESS_BITS     = 32,
  parameter int MSG_BITS         = 4,
  parameter int LINE_OFFSET_BITS = 2,
  parameter int BUS_OFFSET_BITS  = 1,
  localparam int LINE_WIDTH      = DATA_WIDTH << LINE_OFFSET_BITS,
  localparam int BUS_WIDTH       = DATA_WIDTH << BUS_OFFSET_BITS,
  localparam int BEATS           = 1 << (LINE_OFFSET_BITS - BUS_OFFSET_BITS),
  localparam int CNT_W           = log2(BEATS) + 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [MSG_BITS-1:0]     bus_msg_in,
  input  logic [ADDRESS_BITS-1:0] bus_address_in,
  input  logic [BUS_WIDTH-1:0]    bus_data_in,
  input  logic                    req_ready,
  output logic [MSG_BITS-1:0]     bus_msg_out,
  output logic [BUS_WIDTH-1:0]    bus_data_out,
  output logic [CNT_W-1:0]        beat_offset,
  output logic [MSG_BITS-1:0]     mem_msg_out,
  output logic [ADDRESS_BITS-1:0] mem_address_out,
  output logic [LINE_WIDTH-1:0]   mem_data_out,
  input  logic [MSG_BITS-1:0]     mem_msg_in,
  input  logic [LINE_WIDTH-1:0]   mem_data_in
);

  localparam int BYTE_OFF = LINE_OFFSET_BITS + log2(DATA_WIDTH / 8);
  localparam logic [ADDRESS_BITS-1:0] ADDR_MASK = {ADDRESS_BITS{1'b1}} << BYTE_OFF;

  localparam logic [MSG_BITS-1:0] M_NO     = MSG_BITS'(NO_REQ);
  localparam logic [MSG_BITS-1:0] M_R      = MSG_BITS'(R_REQ);
  localparam logic [MSG_BITS-1:0] M_WB     = MSG_BITS'(WB_REQ);
  localparam logic [MSG_BITS-1:0] M_RESP   = MSG_BITS'(MEM_RESP);
  localparam logic [MSG_BITS-1:0] M_RESP_S = MSG_BITS'(MEM_RESP_S);

  typedef enum logic [2:0] {
    IDLE, WB_COLLECT, MEM_WRITE, MEM_READ, RESP_DATA, RESP_ACK, RELEASE
  } state_t;

  state_t                  state, state_next;
  logic [CNT_W-1:0]        cnt;
  logic [CNT_W-1:0]        cnt_inc;
  logic [LINE_WIDTH-1:0]   line;
  logic [ADDRESS_BITS-1:0] addr;
  logic [MSG_BITS-1:0]     code;
  logic                    wb_grant, rd_grant, mem_rd_done, wb_last, rd_last;

  assign cnt_inc     = cnt + CNT_W'(1);
  assign wb_grant    = req_ready && (bus_msg_in == M_WB);
  assign rd_grant    = req_ready && (bus_msg_in == M_R);
  assign mem_rd_done = (mem_msg_in == M_RESP) || (mem_msg_in == M_RESP_S);
  // Beat 0 is taken in IDLE, so the collect phase counts the beat after cnt.
  assign wb_last     = (cnt_inc == CNT_W'(BEATS - 1));
  assign rd_last     = (cnt == CNT_W'(BEATS - 1));
  assign mem_address_out = addr;

  always_comb begin
    state_next   = state;
    bus_msg_out  = M_NO;
    bus_data_out = '0;
    beat_offset  = '0;
    mem_msg_out  = M_NO;
    mem_data_out = '0;
    case (state)
      IDLE: begin
        if (wb_grant)      state_next = (BEATS == 1) ? MEM_WRITE : WB_COLLECT;
        else if (rd_grant) state_next = MEM_READ;
      end
      WB_COLLECT: begin
        beat_offset = cnt_inc;
        if (!req_ready)   state_next = IDLE;
        else if (wb_last) state_next = MEM_WRITE;
      end
      MEM_WRITE: begin
        mem_msg_out  = M_WB;
        mem_data_out = line;
        if (mem_msg_in == M_RESP) state_next = RESP_ACK;
      end
      MEM_READ: begin
        mem_msg_out = M_R;
        if (mem_rd_done) state_next = RESP_DATA;
      end
      RESP_DATA: begin
        bus_msg_out  = code;
        bus_data_out = line[int'(cnt) * BUS_WIDTH +: BUS_WIDTH];
        beat_offset  = cnt;
        if (rd_last) state_next = RELEASE;
      end
      RESP_ACK: begin
        bus_msg_out = M_RESP;
        state_next  = RELEASE;
      end
      RELEASE: begin
        // Hold here until the requester withdraws so a held request is not re-served.
        if (!req_ready || bus_msg_in == M_NO) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      line  <= '0;
      addr  <= '0;
      code  <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (wb_grant || rd_grant) begin
            addr <= bus_address_in & ADDR_MASK;
            cnt  <= '0;
          end
          if (wb_grant) line <= LINE_WIDTH'(bus_data_in);
        end
        WB_COLLECT: begin
          if (!req_ready) begin
            line <= '0;
            cnt  <= '0;
          end else begin
            line[int'(cnt_inc) * BUS_WIDTH +: BUS_WIDTH] <= bus_data_in;
            cnt <= wb_last ? '0 : cnt_inc;
          end
        end
        MEM_READ: begin
          if (mem_rd_done) begin
            line <= mem_data_in;
            code <= mem_msg_in;
            cnt  <= '0;
          end
        end
        RESP_DATA: cnt <= rd_last ? '0 : cnt_inc;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_line_responder.sv
// Directed plus randomized bench for bus_line_responder with a line-level reference model.
module tb_bus_line_responder;
  import bus_line_responder_pkg::*;

  localparam int DW = 32, AW = 32, MB = 4, LOB = 2, BOB = 1;
  localparam int LW = DW << LOB;
  localparam int BW = DW << BOB;
  localparam int BEATS = 1 << (LOB - BOB);
  localparam int CW = log2(BEATS) + 1;
  localparam int LINE_BYTES = LW / 8;

  localparam logic [MB-1:0] C_NO     = MB'(NO_REQ);
  localparam logic [MB-1:0] C_R      = MB'(R_REQ);
  localparam logic [MB-1:0] C_WB     = MB'(WB_REQ);
  localparam logic [MB-1:0] C_RESP   = MB'(MEM_RESP);
  localparam logic [MB-1:0] C_RESP_S = MB'(MEM_RESP_S);

  logic          clock, reset;
  logic [MB-1:0] bus_msg_in, bus_msg_out, mem_msg_out, mem_msg_in;
  logic [AW-1:0] bus_address_in, mem_address_out;
  logic [BW-1:0] bus_data_in, bus_data_out;
  logic          req_ready;
  logic [CW-1:0] beat_offset;
  logic [LW-1:0] mem_data_out, mem_data_in;

  int total = 0;
  int bad   = 0;
  logic [BW-1:0] exp_q[$];

  bus_line_responder #(
    .DATA_WIDTH(DW), .ADDRESS_BITS(AW), .MSG_BITS(MB),
    .LINE_OFFSET_BITS(LOB), .BUS_OFFSET_BITS(BOB)
  ) dut (
    .clock(clock), .reset(reset),
    .bus_msg_in(bus_msg_in), .bus_address_in(bus_address_in), .bus_data_in(bus_data_in),
    .req_ready(req_ready),
    .bus_msg_out(bus_msg_out), .bus_data_out(bus_data_out), .beat_offset(beat_offset),
    .mem_msg_out(mem_msg_out), .mem_address_out(mem_address_out), .mem_data_out(mem_data_out),
    .mem_msg_in(mem_msg_in), .mem_data_in(mem_data_in)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // reference model: a line is memory-aligned and split into equal little-endian beats
  function automatic logic [AW-1:0] line_addr(input logic [AW-1:0] a);
    return a - (a % LINE_BYTES);
  endfunction

  function automatic logic [BW-1:0] beat_of(input logic [LW-1:0] l, input int k);
    return BW'(l >> (k * BW));
  endfunction

  function automatic logic [LW-1:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // driver tasks
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_bus();
    req_ready      = 1'b0;
    bus_msg_in     = C_NO;
    bus_address_in = '0;
    bus_data_in    = '0;
    mem_msg_in     = C_NO;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_bus_msg"}, bus_msg_out, C_NO);
    check({tag, "_mem_msg"}, mem_msg_out, C_NO);
  endtask

  task automatic release_phase(input int hold);
    for (int h = 0; h < hold; h++) begin
      settle();
      check_quiet("release_hold");
      tick();
    end
    if ($urandom_range(0, 1) == 0) req_ready = 1'b0;
    else bus_msg_in = C_NO;
    settle();
    check_quiet("release_drop");
    tick();
    idle_bus();
  endtask

  task automatic wb_txn(input logic [AW-1:0] addr, input logic [LW-1:0] l, input int delay,
                        input int hold);
    req_ready = 1'b1;
    bus_msg_in = C_WB;
    bus_address_in = addr;
    bus_data_in = beat_of(l, 0);
    settle();
    check("wb_idle_mem_msg", mem_msg_out, C_NO);
    check("wb_idle_offset", beat_offset, 0);
    tick();
    for (int k = 1; k < BEATS; k++) begin
      bus_data_in = beat_of(l, k);
      bus_address_in = $urandom;
      settle();
      check("wb_collect_offset", beat_offset, k);
      check("wb_collect_mem_msg", mem_msg_out, C_NO);
      tick();
    end
    bus_data_in = {$urandom, $urandom};
    for (int d = 0; d <= delay; d++) begin
      if (d == delay) mem_msg_in = C_RESP;
      settle();
      check("wb_mem_msg", mem_msg_out, C_WB);
      check("wb_mem_data", mem_data_out, l);
      check("wb_mem_addr", mem_address_out, line_addr(addr));
      check("wb_bus_msg", bus_msg_out, C_NO);
      tick();
    end
    mem_msg_in = C_NO;
    settle();
    check("wb_ack_bus_msg", bus_msg_out, C_RESP);
    check("wb_ack_mem_msg", mem_msg_out, C_NO);
    tick();
    release_phase(hold);
  endtask

  task automatic rd_txn(input logic [AW-1:0] addr, input logic [LW-1:0] l,
                        input logic [MB-1:0] resp, input int delay, input int hold);
    req_ready = 1'b1;
    bus_msg_in = C_R;
    bus_address_in = addr;
    settle();
    check("rd_idle_mem_msg", mem_msg_out, C_NO);
    tick();
    bus_address_in = $urandom;
    for (int d = 0; d <= delay; d++) begin
      if (d == delay) begin
        mem_msg_in = resp;
        mem_data_in = l;
        for (int k = 0; k < BEATS; k++) exp_q.push_back(beat_of(l, k));
      end
      settle();
      check("rd_mem_msg", mem_msg_out, C_R);
      check("rd_mem_addr", mem_address_out, line_addr(addr));
      check("rd_wait_bus_msg", bus_msg_out, C_NO);
      tick();
    end
    mem_msg_in = C_NO;
    mem_data_in = rand_line();
    for (int k = 0; k < BEATS; k++) begin
      settle();
      check("rd_beat_msg", bus_msg_out, resp);
      check("rd_beat_data", bus_data_out, exp_q.pop_front());
      check("rd_beat_offset", beat_offset, k);
      check("rd_beat_mem_msg", mem_msg_out, C_NO);
      tick();
    end
    release_phase(hold);
  endtask

  initial begin
    reset = 1'b1;
    idle_bus();
    mem_data_in = '0;
    #3;
    check("reset_bus_msg", bus_msg_out, C_NO);
    check("reset_bus_data", bus_data_out, 0);
    check("reset_mem_msg", mem_msg_out, C_NO);
    check("reset_mem_addr", mem_address_out, 0);
    check("reset_mem_data", mem_data_out, 0);
    check("reset_offset", beat_offset, 0);
    tick();
    reset = 1'b0;

    // directed write-back and read
    wb_txn(32'h0000_1144, 128'h11111111_22222222_33333333_44444444, 2, 1);
    rd_txn(32'h8000_5508, 128'h66666666_77777777_88888888_99999999, C_RESP_S, 1, 3);

    // write-back abandoned after beat 0
    req_ready = 1'b1;
    bus_msg_in = C_WB;
    bus_address_in = 32'h0000_2200;
    bus_data_in = 64'hdead_beef_0000_0001;
    tick();
    req_ready = 1'b0;
    settle();
    check("abort_offset", beat_offset, 1);
    tick();
    idle_bus();
    for (int i = 0; i < 3; i++) begin
      settle();
      check_quiet("abort");
      tick();
    end
    rd_txn(32'h0000_3030, rand_line(), C_RESP, 0, 0);

    // reset in the middle of a read
    req_ready = 1'b1;
    bus_msg_in = C_R;
    bus_address_in = 32'h4000_0010;
    tick();
    settle();
    check("midrst_pre_mem_msg", mem_msg_out, C_R);
    reset = 1'b1;
    idle_bus();
    #1;
    check("midrst_mem_msg", mem_msg_out, C_NO);
    check("midrst_mem_addr", mem_address_out, 0);
    check("midrst_bus_msg", bus_msg_out, C_NO);
    check("midrst_offset", beat_offset, 0);
    tick();
    reset = 1'b0;
    rd_txn(32'h4000_0010, rand_line(), C_RESP, 2, 1);

    // stray memory response while idle
    mem_msg_in = C_RESP;
    mem_data_in = rand_line();
    for (int i = 0; i < 3; i++) begin
      settle();
      check_quiet("stray");
      check("stray_bus_data", bus_data_out, 0);
      tick();
    end
    mem_msg_in = C_NO;
    wb_txn(32'h0000_5A5C, rand_line(), 0, 2);

    // randomized traffic
    for (int n = 0; n < 16; n++) begin
      if ($urandom_range(0, 1) == 0)
        wb_txn($urandom, rand_line(), $urandom_range(0, 3), $urandom_range(0, 2));
      else
        rd_txn($urandom, rand_line(), ($urandom_range(0, 1) == 0) ? C_RESP : C_RESP_S,
               $urandom_range(0, 3), $urandom_range(0, 2));
    end

    check("final_exp_q_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
